// File: rtl/execute_ctrl_if.sv
// Signal bundle between the decode/memory/writeback stages, the shared ALU and
// the execute-stage controller; the slave side is the execute controller.
interface execute_ctrl_if;
    logic        E_stall;
    logic        E_bubble;
    logic [3:0]  d_stat;
    logic [3:0]  d_icode;
    logic [3:0]  d_ifun;
    logic [63:0] d_valC;
    logic [63:0] d_valA;
    logic [63:0] d_valB;
    logic [3:0]  d_dstE;
    logic [3:0]  d_dstM;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  m_stat;
    logic [3:0]  W_stat;
    logic [63:0] alu_out;
    logic        alu_of;
    logic [63:0] alu_a;
    logic [63:0] alu_b;
    logic [1:0]  alu_fun;
    logic [3:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [3:0]  E_dstM;
    logic [3:0]  E_srcA;
    logic [3:0]  E_srcB;
    logic [63:0] E_valA;
    logic [63:0] e_valE;
    logic        e_cnd;
    logic [3:0]  e_dstE;
    logic [2:0]  cc;

    modport slave (
        input  E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat, alu_out, alu_of,
        output alu_a, alu_b, alu_fun, E_stat, E_icode, E_ifun, E_dstM, E_srcA,
               E_srcB, E_valA, e_valE, e_cnd, e_dstE, cc
    );

    modport master (
        output E_stall, E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
               d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat, alu_out, alu_of,
        input  alu_a, alu_b, alu_fun, E_stat, E_icode, E_ifun, E_dstM, E_srcA,
               E_srcB, E_valA, e_valE, e_cnd, e_dstE, cc
    );
endinterface

// File: rtl/execute_ctrl.sv
// Execute stage of a Y86-64 style pipeline: E pipeline register, ALU operand
// selection, condition-code register and branch/cmov condition evaluation.
module execute_ctrl #(
    parameter logic [3:0] RNONE = 4'hF
) (
    input logic          clk,
    input logic          rst,
    execute_ctrl_if.slave bus
);
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] S_AOK   = 4'h1;

    logic [3:0]  r_stat, r_icode, r_ifun;
    logic [63:0] r_valC, r_valA, r_valB;
    logic [3:0]  r_dstE, r_dstM, r_srcA, r_srcB;
    logic [2:0]  r_cc;

    logic        w_set_cc;
    logic        w_m_exc, w_w_exc;
    logic        w_zf, w_sf, w_of;
    logic        w_cnd;
    logic [63:0] w_alu_a, w_alu_b;
    logic [1:0]  w_alu_fun;

    // Stall outranks bubble so a held instruction is never silently squashed.
    always_ff @(posedge clk) begin
        if (rst || (!bus.E_stall && bus.E_bubble)) begin
            r_stat  <= S_AOK;
            r_icode <= I_NOP;
            r_ifun  <= 4'h0;
            r_valC  <= 64'd0;
            r_valA  <= 64'd0;
            r_valB  <= 64'd0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_srcA  <= RNONE;
            r_srcB  <= RNONE;
        end else if (!bus.E_stall) begin
            r_stat  <= bus.d_stat;
            r_icode <= bus.d_icode;
            r_ifun  <= bus.d_ifun;
            r_valC  <= bus.d_valC;
            r_valA  <= bus.d_valA;
            r_valB  <= bus.d_valB;
            r_dstE  <= bus.d_dstE;
            r_dstM  <= bus.d_dstM;
            r_srcA  <= bus.d_srcA;
            r_srcB  <= bus.d_srcB;
        end
    end

    assign w_m_exc  = (bus.m_stat == 4'h2) || (bus.m_stat == 4'h3) || (bus.m_stat == 4'h4);
    assign w_w_exc  = (bus.W_stat == 4'h2) || (bus.W_stat == 4'h3) || (bus.W_stat == 4'h4);
    assign w_set_cc = (r_icode == I_OPQ) && !w_m_exc && !w_w_exc;

    // Flags follow the instruction in E even while E is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cc <= 3'b001;
        end else if (w_set_cc) begin
            r_cc <= {bus.alu_of, bus.alu_out[63], (bus.alu_out == 64'd0)};
        end
    end

    always_comb begin
        w_alu_a = 64'd0;
        case (r_icode)
            I_CMOV, I_OPQ:                 w_alu_a = r_valA;
            I_IRMOV, I_RMMOV, I_MRMOV:     w_alu_a = r_valC;
            I_CALL, I_RET, I_PUSH, I_POP:  w_alu_a = 64'd8;
            default:                       w_alu_a = 64'd0;
        endcase
    end

    always_comb begin
        w_alu_b = 64'd0;
        case (r_icode)
            I_RMMOV, I_MRMOV, I_OPQ, I_CALL, I_RET, I_PUSH, I_POP: w_alu_b = r_valB;
            default:                                               w_alu_b = 64'd0;
        endcase
    end

    always_comb begin
        w_alu_fun = 2'd0;
        case (r_icode)
            I_OPQ:          w_alu_fun = r_ifun[1:0];
            I_CALL, I_PUSH: w_alu_fun = 2'd1;
            default:        w_alu_fun = 2'd0;
        endcase
    end

    assign w_zf = r_cc[0];
    assign w_sf = r_cc[1];
    assign w_of = r_cc[2];

    always_comb begin
        w_cnd = 1'b0;
        case (r_ifun)
            4'h0:    w_cnd = 1'b1;
            4'h1:    w_cnd = (w_sf ^ w_of) | w_zf;
            4'h2:    w_cnd = w_sf ^ w_of;
            4'h3:    w_cnd = w_zf;
            4'h4:    w_cnd = ~w_zf;
            4'h5:    w_cnd = ~(w_sf ^ w_of);
            4'h6:    w_cnd = ~(w_sf ^ w_of) & ~w_zf;
            default: w_cnd = 1'b0;
        endcase
    end

    assign bus.alu_a   = w_alu_a;
    assign bus.alu_b   = w_alu_b;
    assign bus.alu_fun = w_alu_fun;
    assign bus.e_valE  = bus.alu_out;
    assign bus.e_cnd   = w_cnd;
    assign bus.e_dstE  = ((r_icode == I_CMOV) && !w_cnd) ? RNONE : r_dstE;
    assign bus.cc      = r_cc;
    assign bus.E_stat  = r_stat;
    assign bus.E_icode = r_icode;
    assign bus.E_ifun  = r_ifun;
    assign bus.E_dstM  = r_dstM;
    assign bus.E_srcA  = r_srcA;
    assign bus.E_srcB  = r_srcB;
    assign bus.E_valA  = r_valA;
endmodule

// File: doc/execute_ctrl.md
EXECUTE_CTRL -- requirements
Module: execute_ctrl

Interface
REQ-001 Parameter RNONE, default 4'hF, register ID meaning "no register".
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 E_stall  input  1  hold the E pipeline register.
REQ-005 E_bubble  input  1  load a nop bubble into the E pipeline register.
REQ-006 d_stat  input  4  decode-stage status: 1 AOK, 2 HLT, 3 ADR, 4 INS.
REQ-007 d_icode, d_ifun  input  4 each  decode-stage instruction code and function.
REQ-008 d_valC, d_valA, d_valB  input  64 each  decode-stage operand values.
REQ-009 d_dstE, d_dstM, d_srcA, d_srcB  input  4 each  decode-stage register IDs.
REQ-010 m_stat, W_stat  input  4 each  memory-stage and writeback-stage status.
REQ-011 alu_out  input  64  result from the shared ALU.
REQ-012 alu_of  input  1  signed-overflow flag from the shared ALU.
REQ-013 alu_a, alu_b  output  64 each  ALU operands; alu_out = alu_b OP alu_a.
REQ-014 alu_fun  output  2  ALU op: 0 add, 1 sub (b-a), 2 and, 3 xor.
REQ-015 E_stat, E_icode, E_ifun, E_dstM, E_srcA, E_srcB  output  4 each  registered E-stage fields.
REQ-016 E_valA  output  64  registered E-stage valA, passed through to memory stage.
REQ-017 e_valE  output  64  execute result, equal to alu_out.
REQ-018 e_cnd  output  1  condition outcome for cmov and jXX.
REQ-019 e_dstE  output  4  effective destination; RNONE when a cmov is not taken.
REQ-020 cc  output  3  condition-code register: bit0 ZF, bit1 SF, bit2 OF.

Function
REQ-021 E register update priority on a rising edge: rst, then E_stall (hold all fields), then E_bubble (load bubble), else load all d_* fields.
REQ-022 Bubble contents: stat=1, icode=4'h1 (nop), ifun=0, valC/valA/valB=0, dstE/dstM/srcA/srcB=RNONE.
REQ-023 E_stall and E_bubble both high in the same cycle: stall wins and the register holds.
REQ-024 alu_a selection: icode 2 or 6 -> E_valA; icode 3, 4 or 5 -> E_valC; icode 8, 9, A or B -> 64'd8; any other icode -> 0.
REQ-025 alu_b selection: icode 4, 5, 6, 8, 9, A or B -> E_valB; icode 2 or 3 -> 0; any other icode -> 0.
REQ-026 alu_fun: icode 6 -> E_ifun[1:0]; icode 8 or A -> 1 (sub); all other icodes -> 0 (add).
REQ-027 Operand mux, e_valE, e_cnd and e_dstE are combinational from E register, cc and ALU inputs; zero-cycle latency.
REQ-028 e_cnd from cc and E_ifun: 0 -> 1; 1 -> (SF^OF)|ZF; 2 -> SF^OF; 3 -> ZF; 4 -> ~ZF; 5 -> ~(SF^OF); 6 -> ~(SF^OF)&~ZF; 7..F -> 0.
REQ-029 e_dstE = RNONE when E_icode==2 and e_cnd==0; otherwise E_dstE.
REQ-030 set_cc = (E_icode==6) && m_stat not in {2,3,4} && W_stat not in {2,3,4}.
REQ-031 When set_cc is high at a rising edge, cc loads {alu_of, alu_out[63], (alu_out==0)}; otherwise cc holds.
REQ-032 cc updated by an OPq becomes visible to e_cnd from the next cycle only; same-cycle e_cnd uses the old cc.
REQ-033 E_stall does not block a cc update for the instruction already held in E; only the exception terms in REQ-030 gate it.
REQ-034 Arithmetic is 64-bit modulo 2^64; the block performs no arithmetic beyond the zero test and sign extraction.

Reset
REQ-035 While rst is high at a rising edge: E register loads the bubble of REQ-022 and cc loads 3'b001, regardless of E_stall, E_bubble or set_cc.
REQ-036 After reset and before the next edge: e_valE=alu_out, e_cnd=1 (ifun 0), e_dstE=RNONE, alu_a=0, alu_b=0, alu_fun=0.
REQ-037 rst asserted while an OPq is in E discards that instruction and its cc update.

Verification
REQ-038 rst high 1 cycle -> E_icode=1, E_stat=1, cc=3'b001, e_dstE=4'hF.
REQ-039 Load OPq add (icode 6, ifun 0) with valA=5, valB=7 and ALU model returns 12 -> alu_a=5, alu_b=7, alu_fun=0, e_valE=12; next cycle cc=3'b000.
REQ-040 OPq sub with valA=1, valB=64'h8000_0000_0000_0000, ALU returns 64'h7FFF_FFFF_FFFF_FFFF and of=1 -> next cc=3'b100; a following cmovl (ifun 2) gives e_cnd=1.
REQ-041 cc=3'b001, cmovle (icode 2, ifun 1, dstE=3) -> e_cnd=1, e_dstE=3; cc=3'b000 with the same instruction -> e_cnd=0, e_dstE=4'hF.
REQ-042 OPq in E with m_stat=3 (or W_stat=2) and ALU returning 0 -> cc unchanged across the edge.
REQ-043 E_stall and E_bubble high together for 2 cycles -> E fields unchanged; E_bubble alone -> E_icode=1 and all register IDs 4'hF next cycle.
